// File: rtl/wave_profile_gen.sv
// wave_profile_gen: streams a 1024-sample parabolic-sine profile into the display profile RAM,
// regenerating it on a frequency change or a per-frame scroll tick.
module wave_profile_gen #(
    parameter int CENTER    = 384,
    parameter int AMP_SHIFT = 1,
    parameter int SCROLL    = 256,
    parameter int V_MAX     = 767
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] frequency,
    input  logic        new_f,
    input  logic        frame_tick,
    output logic [10:0] wave_index,
    output logic [9:0]  wave_prof,
    output logic        wave_we,
    output logic        wave_ready
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam int SH = 9 + AMP_SHIFT;
    localparam logic signed [11:0] CEN12 = 12'(CENTER);
    localparam logic signed [11:0] VMAX12 = 12'(V_MAX);
    state_t state;
    logic [15:0] inc, inc_sh, start_phase, phase;
    logic [10:0] n, s1_idx;
    logic [9:0] s1_x, prof_c;
    logic pending, flush_cnt, s1_valid, s1_h;
    logic [19:0] prod;
    logic signed [11:0] y, row;
    always_comb begin
        prod = 20'(s1_x) * 20'(10'd1023 - s1_x);
        y = 12'(prod >> SH);
        row = s1_h ? CEN12 + y : CEN12 - y;
        prof_c = row < 12'sd0 ? 10'd0 : row > VMAX12 ? VMAX12[9:0] : row[9:0];
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            inc <= '0;
            inc_sh <= '0;
            start_phase <= '0;
            phase <= '0;
            n <= '0;
            pending <= 1'b1;
            flush_cnt <= 1'b0;
            s1_valid <= 1'b0;
            s1_h <= 1'b0;
            s1_x <= '0;
            s1_idx <= '0;
            wave_we <= 1'b0;
            wave_index <= '0;
            wave_prof <= 10'(CENTER);
            wave_ready <= 1'b0;
        end else begin
            if (new_f) inc <= {5'b0, frequency};
            if (frame_tick) start_phase <= start_phase + 16'(SCROLL);
            s1_valid <= 1'b0;
            case (state)
                IDLE: if (pending) begin
                    state <= RUN;
                    phase <= start_phase;
                    inc_sh <= inc;
                    n <= '0;
                    pending <= 1'b0;
                    wave_ready <= 1'b0;
                end
                RUN: begin
                    s1_valid <= 1'b1;
                    s1_x <= phase[14:5];
                    s1_h <= phase[15];
                    s1_idx <= n;
                    phase <= phase + inc_sh;
                    n <= n + 11'd1;
                    if (n == 11'd1023) begin
                        state <= FLUSH;
                        flush_cnt <= 1'b0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= IDLE;
                        wave_ready <= !(pending || new_f || frame_tick);
                    end
                end
                default: state <= IDLE;
            endcase
            // a request in the same cycle as sweep start must survive the clear above
            if (new_f || frame_tick) pending <= 1'b1;
            wave_we <= s1_valid;
            if (s1_valid) begin
                wave_index <= s1_idx;
                wave_prof <= prof_c;
            end
        end
    end
endmodule

// File: tb/tb_wave_profile_gen.sv
// tb_wave_profile_gen: directed checks of sweep timing, sample values, request handling and reset.
module tb_wave_profile_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [10:0] frequency = '0;
    logic new_f = 1'b0;
    logic frame_tick = 1'b0;
    logic [10:0] idx1, idx0;
    logic [9:0] prof1, prof0;
    logic we1, we0, rdy1, rdy0;
    int vecs = 0;
    int miscompares = 0;
    int k, seq_err, flat_err, rdy_seen;
    logic [9:0] p1 [1024];
    logic [9:0] p0 [1024];

    wave_profile_gen #(.AMP_SHIFT(1)) dut (
        .clock(clock), .reset(reset), .frequency(frequency), .new_f(new_f),
        .frame_tick(frame_tick), .wave_index(idx1), .wave_prof(prof1),
        .wave_we(we1), .wave_ready(rdy1)
    );
    wave_profile_gen #(.AMP_SHIFT(0)) dut0 (
        .clock(clock), .reset(reset), .frequency(frequency), .new_f(new_f),
        .frame_tick(frame_tick), .wave_index(idx0), .wave_prof(prof0),
        .wave_we(we0), .wave_ready(rdy0)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic nf, input logic ft, input logic [10:0] f);
        frequency = f;
        new_f = nf;
        frame_tick = ft;
        @(negedge clock);
        new_f = 1'b0;
        frame_tick = 1'b0;
    endtask

    // waits (bounded) for the first write, records 1024 samples, optionally pulses new_f=128 at sample inj
    task automatic collect(input string tag, input int inj);
        k = 0;
        seq_err = 0;
        rdy_seen = 0;
        while (!we1 && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({tag, " latency"}, k, 3);
        for (int i = 0; i < 1024; i++) begin
            if (!we1 || !we0 || idx1 != 11'(i) || idx0 != 11'(i)) seq_err++;
            if (rdy1 || rdy0) rdy_seen++;
            p1[i] = prof1;
            p0[i] = prof0;
            if (i == inj) frequency = 11'd128;
            new_f = (i == inj);
            @(negedge clock);
        end
        new_f = 1'b0;
        check({tag, " index sequence"}, seq_err, 0);
        check({tag, " ready during sweep"}, rdy_seen, 0);
        check({tag, " we after"}, int'(we1), 0);
        check({tag, " index after"}, int'(idx1), 1023);
    endtask

    task automatic flat(input string tag);
        flat_err = 0;
        for (int i = 0; i < 1024; i++)
            if (p1[i] != 10'd384 || p0[i] != 10'd384) flat_err++;
        check({tag, " flat profile"}, flat_err, 0);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset we", int'(we1), 0);
        check("reset index", int'(idx1), 0);
        check("reset prof", int'(prof1), 384);
        check("reset ready", int'(rdy1), 0);
        reset = 1'b1;
        collect("boot", -1);
        flat("boot");
        check("boot ready", int'(rdy1), 1);
        repeat (3) @(negedge clock);
        check("idle ready", int'(rdy1), 1);
        check("idle we", int'(we1), 0);

        pulse(1'b1, 1'b0, 11'd64);
        collect("f64", -1);
        check("f64 s0", int'(p1[0]), 384);
        check("f64 s256", int'(p1[256]), 129);
        check("f64 s512", int'(p1[512]), 384);
        check("f64 s768", int'(p1[768]), 639);
        check("f64 amp0 s256 clamp", int'(p0[256]), 0);
        check("f64 amp0 s768 clamp", int'(p0[768]), 767);
        check("f64 amp0 s512", int'(p0[512]), 384);
        check("f64 ready", int'(rdy1), 1);

        pulse(1'b1, 1'b0, 11'd64);
        collect("f64 mid", 500);
        check("f64 mid s768", int'(p1[768]), 639);
        check("f64 mid s1000", int'(p1[1000]), 428);
        check("mid ready in idle", int'(rdy1), 0);
        collect("f128", -1);
        check("f128 s0", int'(p1[0]), 384);
        check("f128 s128", int'(p1[128]), 129);
        check("f128 s384", int'(p1[384]), 639);
        check("f128 ready", int'(rdy1), 1);

        pulse(1'b0, 1'b1, 11'd0);
        collect("scroll", -1);
        check("scroll s0", int'(p1[0]), 377);
        check("scroll amp0 s0", int'(p0[0]), 369);
        check("scroll s128", int'(p1[128]), 129);
        check("scroll ready", int'(rdy1), 1);

        pulse(1'b0, 1'b1, 11'd0);
        k = 0;
        while (!(we1 && idx1 == 11'd300) && k < 400) begin
            @(negedge clock);
            k++;
        end
        check("pre-reset index", int'(idx1), 300);
        reset = 1'b0;
        #1;
        check("mid reset we", int'(we1), 0);
        check("mid reset index", int'(idx1), 0);
        check("mid reset prof", int'(prof1), 384);
        check("mid reset ready", int'(rdy1), 0);
        @(negedge clock);
        @(negedge clock);
        check("held reset we", int'(we1), 0);
        reset = 1'b1;
        collect("reboot", -1);
        flat("reboot");
        check("reboot ready", int'(rdy1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule

// File: doc/wave_profile_gen.md
# wave_profile_gen

Generates the 1024-sample wave profile that the display stage stores and draws, one sample per clock, on the 65 MHz pixel clock. It fills the display's profile RAM through its `wave_index`/`wave_prof`/`wave_we` write port, replacing the constant-384 and ramp test patterns currently driven from the top level. Each sample is a parabolic sine approximation derived from a 16-bit phase accumulator. A new frequency triggers a full regeneration, and a per-frame tick advances the start phase so the wave scrolls.

## Interface
- `CENTER`, 384: vertical rest line, in screen rows.
- `AMP_SHIFT`, 1: extra right shift on the parabola; sets amplitude (0 gives ±511, 1 gives ±255).
- `SCROLL`, 256: start-phase advance per `frame_tick`, modulo 2^16.
- `V_MAX`, 767: largest legal row; output is clamped to 0..`V_MAX`.

- `clock`  in  1  65 MHz system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous reset, active-low (asserted at 0).
- `frequency`  in  11  phase increment per sample; sampled only when `new_f`=1.
- `new_f`  in  1  one-cycle pulse: latch `frequency` and regenerate.
- `frame_tick`  in  1  one-cycle pulse: advance start phase by `SCROLL` and regenerate.
- `wave_index`  out  11  write address, 0..1023.
- `wave_prof`  out  10  write data, a screen row.
- `wave_we`  out  1  write strobe; `wave_index`/`wave_prof` are valid only when it is 1.
- `wave_ready`  out  1  1 = the latest requested profile is fully written.

## Operation
- Registers:
  - `inc[15:0]` = {5'b0, latched frequency}.
  - `start_phase[15:0]`.
  - `phase[15:0]`.
  - sample counter `n[10:0]`.
  - `pending` flag.
- FSM states are IDLE, RUN and FLUSH.
  - IDLE to RUN when `pending`=1. On this transition: `phase`←`start_phase`, `n`←0, `pending`←0.
  - RUN issues one sample per cycle: `phase`←`phase`+`inc` (mod 2^16), `n`←`n`+1. After issuing n=1023, go to FLUSH.
  - FLUSH waits 2 cycles for the pipeline to drain, then returns to IDLE.
- Requests:
  - `new_f`=1 in any state: `inc` is updated and `pending`←1.
  - `frame_tick`=1 in any state: `start_phase`←`start_phase`+`SCROLL` and `pending`←1.
  - Both in the same cycle: both updates apply, and one regeneration results.
  - A request arriving during RUN or FLUSH does not alter the sweep in flight. The current sweep keeps its `inc` (a shadow copy is taken at sweep start) and finishes. A new sweep starts after one IDLE cycle.
- Sample math, per issued phase p:
  - h = p[15], x = p[14:5] (10 bits).
  - y = (x·(1023−x)) >> (9+`AMP_SHIFT`). The product is 20 bits, unsigned.
  - If h=0, the row is `CENTER`−y; if h=1, it is `CENTER`+y. The sum is computed signed, 12 bits wide.
  - The result is clamped: below 0 becomes 0, above `V_MAX` becomes `V_MAX`.
- `wave_ready`:
  - Goes to 0 on the cycle a sweep enters RUN.
  - Goes to 1 on entry to IDLE only if `pending`=0; otherwise it stays 0.
- After reset deassertion, `pending`=1. The first sweep therefore runs automatically with `inc`=0 and `start_phase`=0, giving a flat profile at `CENTER`.

## Timing
- Reset values, asynchronous:
  - FSM=IDLE, `inc`=0, `start_phase`=0, `pending`=1 (takes effect when reset is released).
  - Outputs: `wave_we`=0, `wave_index`=0, `wave_prof`=`CENTER`, `wave_ready`=0.
- Pipeline is 2 stages: stage 1 is phase to x/h registers; stage 2 is multiply, clamp and output registers.
- Let S be the first RUN cycle:
  - `wave_we`=1 on cycles S+2 through S+1025, with `wave_index` = 0..1023 in order and no gaps.
  - `wave_ready` rises at S+1026 if no request is outstanding.
- Minimum request-to-first-write latency from IDLE is 4 cycles: the request is registered, then IDLE to RUN, then 2 pipeline stages.
- `wave_index` never exceeds 1023. After a sweep it holds 1023 with `wave_we`=0.
- Reset asserted mid-sweep: outputs go to their reset values immediately. No further writes occur, and a fresh `CENTER` sweep follows release.

## Test plan
- Release reset with no requests -> 1024 writes, indices 0..1023, every `wave_prof`=384, then `wave_ready`=1 at S+1026.
- `frequency`=64 with a `new_f` pulse, `AMP_SHIFT`=1 -> samples 0, 256, 512 and 768 read 384, 129, 384 and 639 respectively.
- Same stimulus with `AMP_SHIFT`=0 -> sample 256 clamps to 0 and sample 768 clamps to 767.
- `frequency`=64, then one `frame_tick` -> new sweep with `start_phase`=256: sample 0 (x=8, y=7) = 377.
- `new_f` with `frequency`=128 pulsed while write 500 of a `frequency`=64 sweep is in progress -> writes 501..1023 still follow the 64 profile, `wave_ready` stays 0, there is one IDLE cycle, then a full sweep at 128 (sample 128 = 129), then `wave_ready`=1.
- `reset`=0 asserted during write 300 -> `wave_we` drops that same cycle with index 0 and `wave_ready`=0; after release, a full sweep of 384s follows.
